spi_target: RTL and testbench

//  SPI mode-0 target (responder) for the far end of a link driven by our SPI controller; MSB-first, 8-bit frames.

---
 rtl/spi_target.sv | 200 ++++++++++++++++++++
 tb/tb_spi_target.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, MSB-first 8-bit frames, RX FIFO with DC tag,
// CPU-loaded reply byte on MISO, 32-bit memory-mapped register interface.
module spi_target #(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    input  logic        spi_clk_in,
    input  logic        spi_mosi_in,
    input  logic        spi_cs_n_in,
    input  logic        spi_dc_in,
    output logic        spi_miso_out,
    output logic        spi_miso_oe
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, dc_sync;
    logic                   sclk_prev, cs_prev;
    logic [SYNC_STAGES:0]   warm;
    logic                   armed;
    logic                   sclk_s, cs_s, mosi_s, dc_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift, tx_reg;
    logic       tx_pending, overflow, frame_err;
    logic       frame_start, frame_abort, rise_shift, fall_shift, byte_done, load_tx;

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        empty, full, push, pop, do_push, rd_term, rd_term_q;

    logic [3:0] offset;
    logic       wr_en, tx_wr, ctrl_wr, clear_err, flush;
    logic       unused_bits;

    assign offset      = address_in[3:0];
    assign unused_bits = ^{address_in[31:4], write_value_in[31:8]};
    assign wr_en       = sel_in && (|write_mask_in);
    assign tx_wr       = wr_en && (offset == 4'h4);
    assign ctrl_wr     = wr_en && (offset == 4'hC);
    assign clear_err   = ctrl_wr && write_value_in[0];
    assign flush       = ctrl_wr && write_value_in[1];
    assign ready_out   = sel_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            dc_sync   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            warm      <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc_in};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
            // A frame may only start once CS_N has been seen high with real pin data,
            // so a reset released mid-frame ignores the rest of that frame.
            if (warm[SYNC_STAGES] && cs_s)
                armed <= 1'b1;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev;
    assign sclk_fall = !sclk_s && sclk_prev;
    assign cs_rise   = cs_s && !cs_prev;
    assign cs_fall   = !cs_s && cs_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_next  = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next  = IDLE;
                    frame_abort = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rise_shift = (state == SHIFT) && !cs_rise && sclk_rise;
    assign byte_done  = rise_shift && (bit_cnt == 3'd7);
    // The fall right after the 8th rise must not shift, or the freshly reloaded MSB is lost.
    assign fall_shift = (state == SHIFT) && !cs_rise && sclk_fall && (bit_cnt != 3'd0);
    assign load_tx    = frame_start || byte_done;
    assign push       = byte_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_reg     <= '0;
            tx_pending <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (frame_start)     bit_cnt <= '0;
            else if (rise_shift) bit_cnt <= bit_cnt + 3'd1;

            if (rise_shift) rx_shift <= {rx_shift[6:0], mosi_s};

            if (load_tx)         tx_shift <= tx_pending ? tx_reg : IDLE_BYTE;
            else if (fall_shift) tx_shift <= {tx_shift[6:0], 1'b0};

            if (tx_wr) begin
                tx_reg     <= write_value_in[7:0];
                tx_pending <= 1'b1;
            end else if (load_tx) begin
                tx_pending <= 1'b0;
            end

            if (frame_abort && (bit_cnt != 3'd0)) frame_err <= 1'b1;
            else if (clear_err)                   frame_err <= 1'b0;

            if (push && full && !pop && !flush) overflow <= 1'b1;
            else if (clear_err)                 overflow <= 1'b0;
        end
    end

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign rd_term = sel_in && read_in && (offset == 4'h0);
    assign pop     = rd_term && !rd_term_q && !empty && !flush;
    assign do_push = push && (!full || pop) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_term_q <= 1'b0;
        end else begin
            rd_term_q <= rd_term;
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {dc_s, rx_shift[6:0], mosi_s};
    end

    always_comb begin
        read_value_out = '0;
        if (sel_in && read_in) begin
            case (offset)
                4'h0: if (!empty) read_value_out = {23'b0, mem[rd_ptr[AW-1:0]]};
                4'h8: read_value_out = {26'b0, frame_err, overflow, tx_pending,
                                        (state == SHIFT), full, !empty};
                default: read_value_out = '0;
            endcase
        end
    end

    assign spi_miso_out = (state == SHIFT) ? tx_shift[7] : 1'b1;
    assign spi_miso_oe  = (state == SHIFT);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bus register access, SPI frames driven bit by bit,
// FIFO full/overflow, partial-frame error, flush and mid-frame reset.
module tb_spi_target;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address_in;
    logic        sel_in, read_in;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic        ready_out;
    logic        spi_clk_in, spi_mosi_in, spi_cs_n_in, spi_dc_in;
    logic        spi_miso_out, spi_miso_oe;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int HALF = 6;

    spi_target #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
        .write_mask_in(write_mask_in), .write_value_in(write_value_in),
        .read_value_out(read_value_out), .ready_out(ready_out),
        .spi_clk_in(spi_clk_in), .spi_mosi_in(spi_mosi_in),
        .spi_cs_n_in(spi_cs_n_in), .spi_dc_in(spi_dc_in),
        .spi_miso_out(spi_miso_out), .spi_miso_oe(spi_miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        address_in     = {28'h0, off};
        write_value_in = data;
        write_mask_in  = 4'hF;
        sel_in         = 1'b1;
        @(negedge clk);
        sel_in        = 1'b0;
        write_mask_in = 4'h0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
        address_in = {28'h0, off};
        sel_in     = 1'b1;
        read_in    = 1'b1;
        #2;
        data = read_value_out;
        @(negedge clk);
        sel_in  = 1'b0;
        read_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(off, v);
        check(tag, v, exp);
    endtask

    task automatic spi_bits(input logic [7:0] data, input int n, input logic dc,
                            output logic [7:0] miso_bits);
        miso_bits = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi_in = data[7-i];
            spi_dc_in   = dc;
            repeat (HALF) @(negedge clk);
            miso_bits  = {miso_bits[6:0], spi_miso_out};
            spi_clk_in = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_clk_in = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs_n_in = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_cs_n_in = 1'b1;
        repeat (HALF + 2) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  m;
        logic [31:0] v;
        reset = 1'b1;
        address_in = '0; sel_in = 1'b0; read_in = 1'b0;
        write_mask_in = '0; write_value_in = '0;
        spi_clk_in = 1'b0; spi_mosi_in = 1'b0; spi_cs_n_in = 1'b1; spi_dc_in = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_miso", {31'b0, spi_miso_out}, 32'h1);
        check("rst_oe", {31'b0, spi_miso_oe}, 32'h0);
        check("rst_rdval", read_value_out, 32'h0);
        sel_in = 1'b1;
        #1 check("ready_sel1", {31'b0, ready_out}, 32'h1);
        sel_in = 1'b0;
        #1 check("ready_sel0", {31'b0, ready_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        read_check("status_after_rst", 4'h8, 32'h00);

        // Single byte with DC=1
        cs_low();
        spi_bits(8'hA5, 8, 1'b1, m);
        cs_high();
        read_check("a5_status", 4'h8, 32'h01);
        read_check("a5_rxdata", 4'h0, 32'h1A5);
        read_check("a5_status_empty", 4'h8, 32'h00);

        // Reply byte shifted out on MISO
        bus_write(4'h4, 32'h3C);
        read_check("tx_pending_set", 4'h8, 32'h08);
        cs_low();
        read_check("tx_pending_clr_active", 4'h8, 32'h04);
        check("oe_in_frame", {31'b0, spi_miso_oe}, 32'h1);
        spi_bits(8'h00, 8, 1'b0, m);
        check("miso_3c", {24'b0, m}, 32'h3C);
        cs_high();
        check("oe_idle", {31'b0, spi_miso_oe}, 32'h0);
        read_check("rx_00", 4'h0, 32'h000);

        // Nine bytes into an 8-deep FIFO
        cs_low();
        for (int k = 1; k <= 9; k++) spi_bits(8'(k), 8, 1'b0, m);
        cs_high();
        read_check("ovf_status", 4'h8, 32'h13);
        for (int k = 1; k <= 8; k++) read_check($sformatf("ovf_rx%0d", k), 4'h0, 32'(k));
        read_check("ovf_rx_empty", 4'h0, 32'h0);
        read_check("ovf_status_after", 4'h8, 32'h10);

        // Clear, then partial frame
        bus_write(4'hC, 32'h1);
        read_check("clr_status", 4'h8, 32'h00);
        cs_low();
        spi_bits(8'hB0, 5, 1'b0, m);
        cs_high();
        read_check("ferr_status", 4'h8, 32'h20);
        read_check("ferr_rx_empty", 4'h0, 32'h0);
        bus_write(4'hC, 32'h1);
        read_check("ferr_cleared", 4'h8, 32'h00);

        // Back-to-back bytes without a reply loaded
        cs_low();
        spi_bits(8'h55, 8, 1'b0, m);
        check("b2b_miso0", {24'b0, m}, 32'hFF);
        spi_bits(8'hAA, 8, 1'b1, m);
        check("b2b_miso1", {24'b0, m}, 32'hFF);
        cs_high();
        read_check("b2b_status", 4'h8, 32'h01);
        address_in = 32'h0; sel_in = 1'b1; read_in = 1'b1;
        #2 check("held_read", read_value_out, 32'h055);
        repeat (3) @(negedge clk);
        sel_in = 1'b0; read_in = 1'b0;
        @(negedge clk);
        read_check("held_one_pop", 4'h0, 32'h1AA);
        read_check("b2b_status_empty", 4'h8, 32'h00);

        // Flush
        cs_low();
        spi_bits(8'h77, 8, 1'b0, m);
        cs_high();
        read_check("pre_flush", 4'h8, 32'h01);
        bus_write(4'hC, 32'h2);
        read_check("post_flush", 4'h8, 32'h00);

        // Reset in the middle of a frame
        cs_low();
        spi_bits(8'hF0, 4, 1'b0, m);
        reset = 1'b1;
        #1;
        check("midrst_oe", {31'b0, spi_miso_oe}, 32'h0);
        check("midrst_miso", {31'b0, spi_miso_out}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        spi_bits(8'h0F, 4, 1'b0, m);
        spi_bits(8'h12, 8, 1'b0, m);
        check("midrst_oe_after", {31'b0, spi_miso_oe}, 32'h0);
        read_check("midrst_no_push", 4'h8, 32'h00);
        cs_high();
        cs_low();
        spi_bits(8'h42, 8, 1'b0, m);
        cs_high();
        read_check("midrst_recover", 4'h0, 32'h042);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
